move_command_encoder: RTL and testbench

Front-end command source for the Tetris block-drawing state machine. Takes raw active-low player keys and the game mode, then debounces, prioritises and edge-converts them into the 4-bit `changeblock` command code consumed by the draw/move controller. Injects gravity `Down_` commands on a fixed period. Holds each command until the controller acknowledges completion, which gives exactly one move per press.

---
 rtl/move_command_encoder.sv | 212 +++++++++++++++++++++
 tb/tb_move_command_encoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_command_encoder.sv
// move_command_encoder: turns raw active-low player keys into one-shot
// changeblock command codes for the block draw/move controller. It also
// injects gravity Down_ commands on a fixed period.
// Optional feature: define AUTO_REPEAT_EN to re-issue a held Left/Right/Down
// command every REPEAT_CYCLES cycles while the controller sits in HOLD.
//
// state | meaning
// IDLE  | no command outstanding, outputs NothingButton
// ISSUE | command code latched, cmdValid high until cmdAck
// HOLD  | key command acked, outputs wait code until the key is released
module move_command_encoder #(
    parameter int DB_CYCLES     = 4,
    parameter int GRAV_CYCLES   = 64,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [4:0] keyN,
    input  logic [1:0] mode,
    input  logic       cmdAck,
    output logic [3:0] changeblock,
    output logic       cmdValid,
    output logic       gravTick
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [3:0] NOT_PLAY = 4'b0000;
    localparam logic [3:0] NOTHING  = 4'b0001;
    localparam logic [3:0] DOWN_CMD = 4'b0101;

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int GRAV_W = $clog2(GRAV_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
    localparam logic [GRAV_W-1:0] GRAV_MAX = GRAV_W'(GRAV_CYCLES - 1);

    logic [4:0]      sync1, sync2, keyLvl;
    logic [DB_W-1:0] dbCnt [5];

    logic [GRAV_W-1:0] gravCnt;
    logic              gravPending;
    logic              playMode, gravWrap, ackDown;

    logic [1:0] state;
    logic       srcGrav;
    logic [2:0] heldKey;
    logic [2:0] pickIdx;
    logic       anyPressed;

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rptCnt;
`else
    // Repeat period has no effect when auto-repeat is compiled out.
    if (REPEAT_CYCLES < 1) begin : gRepeatUnused
    end
`endif

    // Key bit index 0..4 (Drop, Left, Right, Down, Rotate) maps to codes 2..6.
    function automatic logic [3:0] cmdCode(input logic [2:0] idx);
        return {1'b0, idx} + 4'd2;
    endfunction

    // Wait codes 7..10 follow the same order; Drop has no wait code.
    function automatic logic [3:0] waitCode(input logic [2:0] idx);
        return (idx == 3'd0) ? NOTHING : ({1'b0, idx} + 4'd6);
    endfunction

    assign playMode = (mode == 2'b01);
    assign gravWrap = playMode && (gravCnt == GRAV_MAX);
    assign ackDown  = playMode && (state == ISSUE) && cmdAck && (changeblock == DOWN_CMD);

    // Two-flop synchroniser for the asynchronous keys.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= keyN;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: flip the level after DB_CYCLES consecutive differing samples.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            keyLvl <= '1;
            for (int i = 0; i < 5; i++) dbCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == keyLvl[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_MAX) begin
                    keyLvl[i] <= sync2[i];
                    dbCnt[i]  <= '0;
                end else begin
                    dbCnt[i] <= dbCnt[i] + 1'b1;
                end
            end
        end
    end

    // Highest-priority pressed key; lowest bit index wins.
    always_comb begin
        pickIdx    = 3'd0;
        anyPressed = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (!keyLvl[i]) begin
                pickIdx    = 3'(i);
                anyPressed = 1'b1;
            end
        end
    end

    // Gravity period counter and tick pulse, only running in play mode.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || !playMode) begin
            gravCnt  <= '0;
            gravTick <= 1'b0;
        end else begin
            gravTick <= gravWrap;
            gravCnt  <= gravWrap ? '0 : gravCnt + 1'b1;
        end
    end

    // Pending gravity request: a new tick beats a same-cycle Down_ ack so no tick is lost.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || !playMode) gravPending <= 1'b0;
        else if (gravWrap)        gravPending <= 1'b1;
        else if (ackDown)         gravPending <= 1'b0;
    end

    // Command FSM with registered code and valid outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state       <= IDLE;
            changeblock <= NOT_PLAY;
            cmdValid    <= 1'b0;
            srcGrav     <= 1'b0;
            heldKey     <= 3'd0;
`ifdef AUTO_REPEAT_EN
            rptCnt      <= '0;
`endif
        end else if (!playMode) begin
            state       <= IDLE;
            changeblock <= NOT_PLAY;
            cmdValid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyPressed) begin
                        state       <= ISSUE;
                        changeblock <= cmdCode(pickIdx);
                        cmdValid    <= 1'b1;
                        srcGrav     <= 1'b0;
                        heldKey     <= pickIdx;
                    end else if (gravPending) begin
                        state       <= ISSUE;
                        changeblock <= DOWN_CMD;
                        cmdValid    <= 1'b1;
                        srcGrav     <= 1'b1;
                        heldKey     <= 3'd3;
                    end else begin
                        changeblock <= NOTHING;
                        cmdValid    <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (cmdAck) begin
                        cmdValid <= 1'b0;
                        if (srcGrav) begin
                            state       <= IDLE;
                            changeblock <= NOTHING;
                        end else begin
                            state       <= HOLD;
                            changeblock <= waitCode(heldKey);
`ifdef AUTO_REPEAT_EN
                            rptCnt      <= '0;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (keyLvl[heldKey]) begin
                        state       <= IDLE;
                        changeblock <= NOTHING;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (heldKey >= 3'd1 && heldKey <= 3'd3) begin
                        if (rptCnt == REP_MAX) begin
                            state       <= ISSUE;
                            changeblock <= cmdCode(heldKey);
                            cmdValid    <= 1'b1;
                        end else begin
                            rptCnt <= rptCnt + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state       <= IDLE;
                    changeblock <= NOTHING;
                    cmdValid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_command_encoder.sv
// Testbench for move_command_encoder: directed test-plan steps followed by
// random key/ack/mode/reset traffic. All of it is checked every cycle
// against a behavioural model of the command rules.
module tb_move_command_encoder;

    localparam int DB   = 4;
    localparam int GRAV = 64;
    localparam int REP  = 16;

`ifdef AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       Resetn;
    logic [4:0] keyN;
    logic [1:0] mode;
    logic       cmdAck;
    logic [3:0] changeblock;
    logic       cmdValid;
    logic       gravTick;

    int passCnt  = 0;
    int checkCnt = 0;
    int failCnt  = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    move_command_encoder #(
        .DB_CYCLES    (DB),
        .GRAV_CYCLES  (GRAV),
        .REPEAT_CYCLES(REP)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .keyN       (keyN),
        .mode       (mode),
        .cmdAck     (cmdAck),
        .changeblock(changeblock),
        .cmdValid   (cmdValid),
        .gravTick   (gravTick)
    );

    // Behavioural model. rawHist[k] is the key vector that was present k edges ago.
    logic [4:0] rawHist [0:DB+1];
    logic [4:0] mLvl;
    int         mGcnt;
    bit         mPend;
    bit         mTick;
    logic [3:0] mCb;
    bit         mValid;
    int         mPhase;     // 0 nothing outstanding, 1 offered, 2 waiting for release
    int         mKey;
    bit         mFromGrav;
    int         mRep;

    task automatic modelEdge();
        logic [4:0] newLvl;
        bit tickNow;
        bit allDiff;
        bit found;
        for (int k = DB + 1; k > 0; k--) rawHist[k] = rawHist[k-1];
        rawHist[0] = keyN;
        // A key level flips once the last DB synchronised samples all disagree with it.
        newLvl = mLvl;
        for (int b = 0; b < 5; b++) begin
            allDiff = 1'b1;
            for (int k = 2; k <= DB + 1; k++) if (rawHist[k][b] == mLvl[b]) allDiff = 1'b0;
            if (allDiff) newLvl[b] = ~mLvl[b];
        end
        if (!Resetn) begin
            for (int k = 0; k <= DB + 1; k++) rawHist[k] = '1;
            mLvl = '1; mGcnt = 0; mPend = 0; mTick = 0;
            mCb = 4'd0; mValid = 0; mPhase = 0; mRep = 0;
            return;
        end
        if (mode != 2'b01) begin
            mPhase = 0; mCb = 4'd0; mValid = 0; mGcnt = 0; mPend = 0; mTick = 0;
            mLvl = newLvl;
            return;
        end
        tickNow = (mGcnt == GRAV - 1);
        mGcnt   = (mGcnt + 1) % GRAV;
        case (mPhase)
            0: begin
                found = 1'b0;
                for (int b = 0; b < 5; b++) begin
                    if (!found && !mLvl[b]) begin
                        found = 1'b1;
                        mKey  = b;
                    end
                end
                if (found) begin
                    mCb = 4'(mKey + 2); mValid = 1; mFromGrav = 0; mPhase = 1;
                end else if (mPend) begin
                    mCb = 4'd5; mValid = 1; mFromGrav = 1; mPhase = 1;
                end else begin
                    mCb = 4'd1; mValid = 0;
                end
            end
            1: begin
                if (cmdAck) begin
                    if (mCb == 4'd5) mPend = 0;
                    mValid = 0;
                    if (mFromGrav) begin
                        mPhase = 0; mCb = 4'd1;
                    end else begin
                        mPhase = 2; mRep = 0;
                        mCb = (mKey == 0) ? 4'd1 : 4'(mKey + 6);
                    end
                end
            end
            default: begin
                if (mLvl[mKey]) begin
                    mPhase = 0; mCb = 4'd1;
                end else if (REPEAT_ON && mKey >= 1 && mKey <= 3) begin
                    mRep++;
                    if (mRep == REP) begin
                        mPhase = 1; mCb = 4'(mKey + 2); mValid = 1;
                    end
                end
            end
        endcase
        if (tickNow) mPend = 1;
        mTick = tickNow;
        mLvl  = newLvl;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        modelEdge();
        #1;
        check("model_changeblock", changeblock, mCb);
        check("model_cmdValid", {3'b000, cmdValid}, {3'b000, mValid});
        check("model_gravTick", {3'b000, gravTick}, {3'b000, mTick});
    endtask

    task automatic restartPlay();
        mode = 2'b00;
        repeat (2) step();
        check("mode_off_code", changeblock, 4'd0);
        mode = 2'b01;
    endtask

    task automatic ack();
        cmdAck = 1'b1;
        step();
        cmdAck = 1'b0;
    endtask

    initial begin
        int hold;
        for (int k = 0; k <= DB + 1; k++) rawHist[k] = '1;
        mLvl = '1; mGcnt = 0; mPend = 0; mTick = 0; mCb = 4'd0; mValid = 0;
        mPhase = 0; mKey = 0; mFromGrav = 0; mRep = 0;
        Resetn = 1'b0; mode = 2'b01; keyN = '1; cmdAck = 1'b0;

        // Reset state.
        repeat (3) step();
        check("reset_code", changeblock, 4'd0);
        check("reset_valid", {3'b000, cmdValid}, 4'd0);
        check("reset_tick", {3'b000, gravTick}, 4'd0);
        Resetn = 1'b1;
        repeat (3) step();
        check("idle_code", changeblock, 4'd1);

        // Left press: code appears DB+3 cycles after the raw edge.
        keyN = 5'b11101;
        repeat (6) step();
        check("left_early", changeblock, 4'd1);
        step();
        check("left_issue", changeblock, 4'd3);
        check("left_valid", {3'b000, cmdValid}, 4'd1);
        repeat (10) step();
        check("left_held", changeblock, 4'd3);
        ack();
        check("left_wait", changeblock, 4'd7);
        check("left_wait_valid", {3'b000, cmdValid}, 4'd0);
        repeat (5) step();
        keyN = '1;
        repeat (7) step();
        check("left_release", changeblock, 4'd1);

        // Three-cycle glitch on Right never becomes a command.
        restartPlay();
        repeat (2) step();
        keyN = 5'b11011;
        repeat (3) step();
        keyN = '1;
        repeat (10) step();
        check("glitch_code", changeblock, 4'd1);
        check("glitch_valid", {3'b000, cmdValid}, 4'd0);

        // Drop and Down together: Drop wins, Down waits for Drop release.
        restartPlay();
        repeat (2) step();
        keyN = 5'b10110;
        repeat (7) step();
        check("drop_issue", changeblock, 4'd2);
        ack();
        check("drop_hold", changeblock, 4'd1);
        repeat (10) step();
        check("drop_hold_valid", {3'b000, cmdValid}, 4'd0);
        keyN = 5'b10111;
        repeat (7) step();
        check("drop_release", changeblock, 4'd1);
        step();
        check("down_after_drop", changeblock, 4'd5);
        ack();
        check("down_wait", changeblock, 4'd9);
        keyN = '1;
        repeat (8) step();

        // Gravity after 64 idle play cycles; acked gravity goes straight to idle.
        restartPlay();
        repeat (63) step();
        check("grav_pre", {3'b000, gravTick}, 4'd0);
        step();
        check("grav_tick", {3'b000, gravTick}, 4'd1);
        step();
        check("grav_issue", changeblock, 4'd5);
        check("grav_valid", {3'b000, cmdValid}, 4'd1);
        ack();
        check("grav_ack_idle", changeblock, 4'd1);
        step();
        check("grav_no_hold", changeblock, 4'd1);

        // Leaving play mode mid-command drops it and clears the gravity counter.
        restartPlay();
        repeat (2) step();
        keyN = 5'b11101;
        repeat (7) step();
        check("mode_issue", changeblock, 4'd3);
        mode = 2'b00;
        step();
        check("mode_off_cb", changeblock, 4'd0);
        check("mode_off_valid", {3'b000, cmdValid}, 4'd0);
        step();
        mode = 2'b01;
        step();
        check("mode_resume", changeblock, 4'd3);
        ack();
        keyN = '1;
        repeat (61) step();
        check("grav_cleared_pre", {3'b000, gravTick}, 4'd0);
        step();
        check("grav_cleared_tick", {3'b000, gravTick}, 4'd1);
        step();
        ack();

        // Held Right: wait code until release, or reissue every REP cycles with auto-repeat.
        restartPlay();
        repeat (2) step();
        keyN = 5'b11011;
        repeat (7) step();
        check("right_issue", changeblock, 4'd4);
        ack();
`ifdef AUTO_REPEAT_EN
        repeat (15) step();
        check("right_wait", changeblock, 4'd8);
        step();
        check("right_repeat", changeblock, 4'd4);
        ack();
`else
        repeat (40) step();
        check("right_no_repeat", changeblock, 4'd8);
`endif
        keyN = '1;
        repeat (8) step();

        // Reset in the middle of a command.
        restartPlay();
        repeat (2) step();
        keyN = 5'b11101;
        repeat (7) step();
        check("reset_mid_issue", changeblock, 4'd3);
        Resetn = 1'b0;
        step();
        check("reset_mid_code", changeblock, 4'd0);
        check("reset_mid_valid", {3'b000, cmdValid}, 4'd0);
        Resetn = 1'b1;
        keyN = '1;
        repeat (10) step();

        // Random traffic against the model.
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                keyN = ($urandom_range(0, 2) == 0) ? 5'b11111 : 5'($urandom);
                hold = $urandom_range(1, 14);
            end
            hold--;
            cmdAck = ($urandom_range(0, 3) == 0);
            mode   = ($urandom_range(0, 60) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            Resetn = ($urandom_range(0, 400) != 0);
            step();
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
